// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   state_t    - scanner FSM states
//   CODE_W     - width of the emitted key code
//   lowest_set - index of the lowest set bit (0 when none set)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN             = 2'd0,
        DEBOUNCE_PRESS   = 2'd1,
        PRESSED          = 2'd2,
        DEBOUNCE_RELEASE = 2'd3
    } state_t;

    localparam int CODE_W = 4;

    // Scanning from the top down leaves the lowest set index as the result,
    // which gives the lowest column priority on multi-key presses.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/strobe_gen.sv
// strobe_gen: free-running W-bit counter producing a one-cycle strobe
// every 2**W clk cycles.
//   clk - system clock
//   rst - synchronous reset, active-high (counter to 0)
//   stb - high for one cycle while the counter is all ones
module strobe_gen #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst,
    output logic stb
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    assign stb = (cnt == '1);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the rows of a ROWS x COLS matrix keypad, reads the
// columns back, debounces and encodes one event per key press.
//   clk       - system clock
//   rst       - synchronous reset, active-high
//   row       - row drive, active-low, exactly one bit low
//   col       - column sense, asynchronous, active-low
//   key_valid - one-cycle pulse when a debounced press is accepted
//   key_code  - row_index*COLS + col_index of the last accepted key
//   key_down  - high from accepted press until accepted release
//
// state            | meaning
// -----------------+-----------------------------------------------------
// SCAN             | rotating rows on each strobe, looking for a low column
// DEBOUNCE_PRESS   | row held, counting strobes where columns match pattern
// PRESSED          | key accepted, row held, waiting for all columns high
// DEBOUNCE_RELEASE | counting strobes with all columns high
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int W          = 16,
    parameter int DEBOUNCE_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_down
);

    localparam int          RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [4:0]  DB_N = 5'(DEBOUNCE_N);

    logic            stb;
    logic [COLS-1:0] col_meta, cs;
    state_t          state, next_state;
    logic [RW-1:0]   row_idx;
    logic [3:0]      count;
    logic [4:0]      count_inc;
    logic [COLS-1:0] pattern;

    logic            do_latch, do_accept, do_rotate, do_inc, do_count_one, do_release;
    logic [COLS-1:0] accept_pattern;
    logic [15:0]     col_low;
    logic [3:0]      col_idx;
    logic [CODE_W-1:0] code_calc;

    strobe_gen #(.W(W)) u_strobe_gen (
        .clk (clk),
        .rst (rst),
        .stb (stb)
    );

    assign count_inc = {1'b0, count} + 5'd1;

    // State register plus the datapath it controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta  <= '1;
            cs        <= '1;
            state     <= SCAN;
            row_idx   <= '0;
            count     <= '0;
            pattern   <= '1;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_down  <= 1'b0;
        end else begin
            col_meta  <= col;
            cs        <= col_meta;
            state     <= next_state;
            key_valid <= do_accept;
            if (do_latch) pattern <= cs;
            if (do_count_one || do_latch) count <= 4'd1;
            else if (do_inc)              count <= count_inc[3:0];
            if (do_rotate) row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
            if (do_accept) begin
                key_code <= code_calc;
                key_down <= 1'b1;
            end else if (do_release) begin
                key_down <= 1'b0;
            end
        end
    end

    // Next-state and control decisions; everything here is gated by stb.
    always_comb begin
        next_state   = state;
        do_latch     = 1'b0;
        do_accept    = 1'b0;
        do_rotate    = 1'b0;
        do_inc       = 1'b0;
        do_count_one = 1'b0;
        do_release   = 1'b0;
        if (stb) begin
            case (state)
                SCAN: begin
                    if (cs != '1) begin
                        do_latch = 1'b1;
                        if (DB_N <= 5'd1) begin
                            do_accept  = 1'b1;
                            next_state = PRESSED;
                        end else begin
                            next_state = DEBOUNCE_PRESS;
                        end
                    end else begin
                        do_rotate = 1'b1;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (cs == pattern) begin
                        do_inc = 1'b1;
                        if (count_inc >= DB_N) begin
                            do_accept  = 1'b1;
                            next_state = PRESSED;
                        end
                    end else begin
                        do_rotate  = 1'b1;
                        next_state = SCAN;
                    end
                end
                PRESSED: begin
                    if (cs == '1) begin
                        do_count_one = 1'b1;
                        if (DB_N <= 5'd1) begin
                            do_release = 1'b1;
                            do_rotate  = 1'b1;
                            next_state = SCAN;
                        end else begin
                            next_state = DEBOUNCE_RELEASE;
                        end
                    end
                end
                DEBOUNCE_RELEASE: begin
                    if (cs == '1) begin
                        do_inc = 1'b1;
                        if (count_inc >= DB_N) begin
                            do_release = 1'b1;
                            do_rotate  = 1'b1;
                            next_state = SCAN;
                        end
                    end else begin
                        next_state = PRESSED;
                    end
                end
                default: next_state = SCAN;
            endcase
        end
    end

    // Outputs and code encoding. With a single-strobe debounce the press is
    // accepted from SCAN before pattern is latched, so use cs directly there.
    always_comb begin
        row            = '1;
        row[row_idx]   = 1'b0;
        accept_pattern = (state == SCAN) ? cs : pattern;
        col_low        = '0;
        col_low[COLS-1:0] = ~accept_pattern;
        col_idx        = lowest_set(col_low);
        code_calc      = CODE_W'(int'(row_idx) * COLS + int'(col_idx));
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment driver.
- The display driver strobes anodes out and drives segments. This block strobes rows of a 4x4 matrix keypad out and reads the columns back.
- Per key press it debounces, encodes and emits one key event: a 1-cycle valid pulse, a code, and a held "down" level.
- Sits in the board top next to the display driver. Its code output typically feeds the display's num input.

Parameters:
ROWS, 4, number of row lines driven (active-low)
COLS, 4, number of column lines sensed (active-low, board pull-ups)
W, 16, strobe counter width; one scan step every 2**W clk cycles
DEBOUNCE_N, 4, consecutive matching scan steps required to accept a press or a release (range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
row  output ROWS  row drive, active-low, exactly one bit low at all times
col  input  COLS  column sense, asynchronous, active-low
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  row_index*COLS + col_index of last accepted key; held until next press
key_down  output  1  high from accepted press until accepted release

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state is updated only on posedge clk.
- Reset values: row = 4'b1110 (row 0 low), key_valid = 0, key_code = 0, key_down = 0, state = SCAN, strobe counter = 0, debounce count = 0.
- Input synchronisation: col passes through a 2-flop synchronizer. All decisions use the synchronized value cs. Reset value of cs is all ones.
- Strobe: internal W-bit free-running counter. stb = 1 for one cycle when counter == all ones. All FSM decisions except the key_valid clear happen only on stb.
- Settle time: row changes only on stb. cs is examined at the following stb, giving one full strobe period of settle time.
- SCAN state, on stb:
  - If cs has any bit low: latch pattern P = cs, set count = 1, go to DEBOUNCE_PRESS. row is held.
  - Else: rotate row to the next row. Row ROWS-1 wraps to row 0.
- DEBOUNCE_PRESS state, on stb:
  - If cs == P, increment count.
  - When count reaches DEBOUNCE_N: key_code = current row index*COLS + index of lowest low bit of P. Pulse key_valid for exactly one clk cycle. Set key_down = 1 and go to PRESSED.
  - If cs != P: go to SCAN and rotate row. No event is emitted.
  - With DEBOUNCE_N = 1, the press is accepted on the same stb that leaves SCAN.
- Multi-key: several low bits in P means the lowest column index wins. Keys on other rows are ignored while in PRESSED.
- PRESSED state: row is held.
  - On stb with cs all ones: count = 1, go to DEBOUNCE_RELEASE.
  - Any other cs change, including extra keys on the same row: ignored, no new event.
- DEBOUNCE_RELEASE state, on stb:
  - If cs is all ones, increment count. When count reaches DEBOUNCE_N: key_down = 0, go to SCAN and rotate row.
  - If any cs bit is low: return to PRESSED. key_down stays 1 and no new key_valid is emitted.
- Event latency: a stable press is seen at most ROWS+DEBOUNCE_N strobe periods after it settles. key_valid fires exactly DEBOUNCE_N-1 stb after the SCAN detection stb.
- Reset mid-operation: rst in any state forces the reset values on the next edge. A key still held after reset is re-detected as a fresh press and produces a new key_valid.

Decomposition:
- keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE_PRESS, PRESSED, DEBOUNCE_RELEASE};
  - localparam CODE_W = 4;
  - a lowest-set-bit priority function for the column index.
- Sub-module: reuse the existing strobe_gen (clk, rst, stb), parameterised with W, driven from this block's active-high rst. No new sub-module is needed.

Test Plan:
Bench settings are W=4 (stb every 16 cycles) and DEBOUNCE_N=3; the bench model drives col from a key matrix according to row.
1. Reset: hold rst 3 cycles -> row=1110, key_valid=0, key_code=0, key_down=0. With no key, row sequence 1110,1101,1011,0111,1110 advances one step per stb.
2. Clean press of key (row 2, col 1), held 20 stb -> exactly one key_valid pulse of 1 cycle, key_code=9, key_down=1. After release, key_down=0 after 3 stb, then scanning resumes at row 3.
3. Bounce: key (row 0, col 3) toggles every stb for 6 stb then holds -> no key_valid during bouncing, then a single event with key_code=3.
4. Multi-key: keys (1,0) and (1,2) pressed together -> key_code=4. Releasing (1,0) while holding (1,2) -> no new event, and key_down stays 1 until both are released.
5. Release glitch: a 1-stb re-press during DEBOUNCE_RELEASE -> no second key_valid, and key_down stays 1 through the glitch.
6. Reset mid-PRESSED with key (3,3) held -> outputs go to reset values, then a new key_valid with key_code=15 after detection plus debounce.
